// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scancode (set 2) decoder slice:
//   - decoder FSM state encoding
//   - prefix / modifier scancode constants
// Optional feature macro used by the slice: KBD_SHIFT_EN (shift tracking).
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting for a prefix or a plain make code
        ST_EXT     = 2'd1,  // E0 seen
        ST_BRK     = 2'd2,  // F0 seen
        ST_EXT_BRK = 2'd3   // E0 F0 seen
    } ps2_state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

endpackage

// File: rtl/ps2_scan2ascii.sv
// ----------------------------------------------------------------------------
// ps2_scan2ascii
// Purely combinational set-2 scancode to ASCII lookup.
// Ports:
//   code_i  [7:0]  scancode (without prefixes)
//   ext_i          code was E0-prefixed (extended keys never map)
//   shift_i        shift modifier held: uppercase letters, shifted digits
//   ascii_o [7:0]  ASCII result, 0x00 when unmapped
// ----------------------------------------------------------------------------
module ps2_scan2ascii (
    input  logic [7:0] code_i,
    input  logic       ext_i,
    input  logic       shift_i,
    output logic [7:0] ascii_o
);

    logic [7:0] base;

    // Unshifted lookup
    always_comb begin
        base = 8'h00;
        if (!ext_i) begin
            case (code_i)
                8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";
                8'h23: base = "d";  8'h24: base = "e";  8'h2B: base = "f";
                8'h34: base = "g";  8'h33: base = "h";  8'h43: base = "i";
                8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
                8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";
                8'h4D: base = "p";  8'h15: base = "q";  8'h2D: base = "r";
                8'h1B: base = "s";  8'h2C: base = "t";  8'h3C: base = "u";
                8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
                8'h35: base = "y";  8'h1A: base = "z";
                8'h45: base = "0";  8'h16: base = "1";  8'h1E: base = "2";
                8'h26: base = "3";  8'h25: base = "4";  8'h2E: base = "5";
                8'h36: base = "6";  8'h3D: base = "7";  8'h3E: base = "8";
                8'h46: base = "9";
                8'h29: base = 8'h20;
                8'h5A: base = 8'h0D;
                default: base = 8'h00;
            endcase
        end
    end

    // Shift overlay on top of the base character
    always_comb begin
        ascii_o = base;
        if (shift_i) begin
            if (base >= "a" && base <= "z") begin
                ascii_o = base - 8'h20;
            end else begin
                case (base)
                    "1": ascii_o = "!";  "2": ascii_o = "@";
                    "3": ascii_o = "#";  "4": ascii_o = "$";
                    "5": ascii_o = "%";  "6": ascii_o = "^";
                    "7": ascii_o = "&";  "8": ascii_o = "*";
                    "9": ascii_o = "(";  "0": ascii_o = ")";
                    default: ascii_o = base;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
// Turns a stream of PS/2 set-2 scancode bytes into make/break key events,
// tracking the single currently-held key, suppressing typematic repeats and
// counting distinct presses.
// Ports:
//   clk, rst        clock / synchronous active-low reset
//   in_valid        one-cycle byte strobe from the PS/2 receiver
//   in_data [7:0]   scancode byte, qualified by in_valid
//   key_make        one-cycle pulse, new press decoded
//   key_break       one-cycle pulse, release of the held key decoded
//   key_code [7:0]  scancode of held/last key
//   key_ext         held/last key was E0-prefixed
//   key_ascii [7:0] ASCII of key_code (0x00 if unmapped or extended)
//   key_held        a key is currently pressed
//   press_cnt       count of distinct presses, wraps modulo 2^CNT_W
// Optional feature: define KBD_SHIFT_EN to treat 0x12/0x59 as shift
// modifiers feeding the ASCII lookup instead of ordinary keys.
// ----------------------------------------------------------------------------
import ps2_pkg::*;

module ps2_key_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             key_make,
    output logic             key_break,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic             key_held,
    output logic [CNT_W-1:0] press_cnt
);

    ps2_state_e       state_q, state_d;
    logic             make_q, make_d;
    logic             break_q, break_d;
    logic [7:0]       code_q, code_d;
    logic             ext_q, ext_d;
    logic             held_q, held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shift_down;

    logic make_ev, brk_ev, ev_ext, code_match;

    // Prefix FSM: classifies each accepted byte as prefix, make or break
    always_comb begin
        state_d = state_q;
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        ev_ext  = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_data == SC_EXT)      state_d = ST_EXT;
                    else if (in_data == SC_BRK) state_d = ST_BRK;
                    else                        make_ev = 1'b1;
                end
                ST_EXT: begin
                    if (in_data == SC_BRK)      state_d = ST_EXT_BRK;
                    else if (in_data != SC_EXT) begin
                        make_ev = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk_ev  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    brk_ev  = 1'b1;
                    ev_ext  = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Event matches the key we believe is held (repeat or valid release)
    assign code_match = held_q && (ev_ext == ext_q) && (in_data == code_q);

`ifdef KBD_SHIFT_EN
    logic lsh_q, lsh_d, rsh_q, rsh_d, shift_ev;
    // Left and right shift tracked separately so releasing one keeps the other
    assign shift_ev   = (make_ev || brk_ev) && !ev_ext &&
                        (in_data == SC_LSHIFT || in_data == SC_RSHIFT);
    assign shift_down = lsh_q | rsh_q;
`else
    assign shift_down = 1'b0;
`endif

    always_comb begin
        make_d  = 1'b0;
        break_d = 1'b0;
        code_d  = code_q;
        ext_d   = ext_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
`ifdef KBD_SHIFT_EN
        lsh_d   = lsh_q;
        rsh_d   = rsh_q;
        if (shift_ev) begin
            if (in_data == SC_LSHIFT) lsh_d = make_ev;
            else                      rsh_d = make_ev;
        end else
`endif
        if (make_ev) begin
            if (!code_match) begin
                code_d = in_data;
                ext_d  = ev_ext;
                held_d = 1'b1;
                make_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else if (brk_ev && code_match) begin
            held_d  = 1'b0;
            break_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            make_q  <= 1'b0;
            break_q <= 1'b0;
            code_q  <= 8'h00;
            ext_q   <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef KBD_SHIFT_EN
            lsh_q   <= 1'b0;
            rsh_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            make_q  <= make_d;
            break_q <= break_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
`ifdef KBD_SHIFT_EN
            lsh_q   <= lsh_d;
            rsh_q   <= rsh_d;
`endif
        end
    end

    ps2_scan2ascii u_scan2ascii (
        .code_i  (code_q),
        .ext_i   (ext_q),
        .shift_i (shift_down),
        .ascii_o (key_ascii)
    );

    assign key_make  = make_q;
    assign key_break = break_q;
    assign key_code  = code_q;
    assign key_ext   = ext_q;
    assign key_held  = held_q;
    assign press_cnt = cnt_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of press counter.
REQ-002 SHALL have port: clk  input  1  system clock, all logic on posedge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  one-cycle strobe, scancode byte available from PS/2 receiver.
REQ-005 SHALL have port: in_data  input  8  received scancode byte, qualified by in_valid.
REQ-006 SHALL have port: key_make  output  1  one-cycle pulse, new key press decoded.
REQ-007 SHALL have port: key_break  output  1  one-cycle pulse, release of held key decoded.
REQ-008 SHALL have port: key_code  output  8  scancode of held/last key.
REQ-009 SHALL have port: key_ext  output  1  held/last key was E0-prefixed.
REQ-010 SHALL have port: key_ascii  output  8  ASCII of key_code, 0x00 if unmapped or extended.
REQ-011 SHALL have port: key_held  output  1  a key is currently pressed.
REQ-012 SHALL have port: press_cnt  output  CNT_W  count of distinct key presses.

Function
REQ-013 SHALL implement FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); state advances only on in_valid.
REQ-014 SHALL in IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make event, stay IDLE.
REQ-015 SHALL in EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> make event with ext=1, go IDLE.
REQ-016 SHALL in BRK/EXT_BRK: any byte -> break event (ext=0/1), go IDLE.
REQ-017 SHALL on make event: if key_held=1 and {ext,byte} equals {key_ext,key_code}, treat as typematic repeat (no pulse, no count); else set key_code/key_ext, key_held=1, pulse key_make, increment press_cnt.
REQ-018 SHALL on break event: if {ext,byte} equals {key_ext,key_code} and key_held=1, clear key_held and pulse key_break; else ignore, key_code unchanged.
REQ-019 SHALL register all outputs; key_make/key_break/updated fields appear exactly one cycle after the in_valid byte.
REQ-020 SHALL keep key_make/key_break low except the single pulse cycle; never both high.
REQ-021 SHALL wrap press_cnt modulo 2^CNT_W (all-ones +1 -> 0).
REQ-022 SHALL derive key_ascii combinationally from registered key_code/key_ext (lowercase a-z, 0-9, space 0x29->0x20, enter 0x5A->0x0D).
REQ-023 SHALL ignore in_data when in_valid=0; back-to-back in_valid each cycle SHALL be accepted.

Reset
REQ-024 SHALL on rst=0 set state IDLE, key_make=0, key_break=0, key_code=0x00, key_ext=0, key_held=0, press_cnt=0, key_ascii=0x00; any partial prefix discarded mid-sequence.

Configuration
REQ-025 SHALL with KBD_SHIFT_EN defined: track shift_down from make/break of 0x12 and 0x59 (non-extended); shift codes SHALL not change key_code/key_held/press_cnt nor pulse; letters map uppercase and digits map to shifted symbols while shift_down=1.
REQ-026 SHALL without KBD_SHIFT_EN: 0x12/0x59 are ordinary keys; key_ascii always unshifted.

Structure
REQ-027 SHALL place FSM state enum and constants SC_EXT=0xE0, SC_BRK=0xF0, SC_LSHIFT=0x12, SC_RSHIFT=0x59 in shared package ps2_pkg.
REQ-028 SHALL instantiate one sub-module ps2_scan2ascii (inputs code, ext, shift; output ascii), purely combinational lookup.

Verification
REQ-029 SHALL test: reset, bytes 1C, F0 1C -> make pulse, key_code=0x1C, ascii=0x61, press_cnt=1; then break pulse, key_held=0.
REQ-030 SHALL test: 1C 1C 1C F0 1C -> one key_make, press_cnt=1 (repeats suppressed).
REQ-031 SHALL test: E0 75, E0 F0 75 -> key_ext=1, ascii=0x00, make then break pulses.
REQ-032 SHALL test: press_cnt preset via 255 distinct make/break pairs, one more press -> press_cnt=0.
REQ-033 SHALL test: E0 then rst=0 one cycle, then 1C -> non-extended make, key_ext=0.
REQ-034 SHALL test KBD_SHIFT_EN: 12, 1C -> ascii=0x41, press_cnt=1; without macro same -> press_cnt=2, ascii=0x61.
